// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and queue-entry type for the instruction
//                prefetch queue and its storage FIFO.
//  Contents    : XLEN      - datapath / address width
//                NOP_INST  - instruction presented when the queue is empty
//                PC_STEP   - byte distance between sequential fetches
//                fetch_entry_t - {inst, pc} pair held in the queue
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int               XLEN     = 32;
    localparam logic [XLEN-1:0]  NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [XLEN-1:0]  PC_STEP  = 32'd4;

    // Instruction sits in the upper half so the packed entry reads {inst, pc}.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fifo
//  Description : Synchronous FIFO of DEPTH entries, WIDTH bits each, with a
//                registered head output and a flush that beats push/pop.
//  Ports       : clk      in   clock
//                rst      in   synchronous active-high reset (empties FIFO)
//                clear    in   flush all entries; push/pop ignored that cycle
//                push     in   write pushData at the tail (ignored when full)
//                pushData in   WIDTH-bit entry to write
//                pop      in   remove the head entry (ignored when empty)
//                head     out  current head entry (stale data when empty)
//                count    out  number of valid entries, 0..DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    logic w_doPush;
    logic w_doPop;

    // Pointers wrap explicitly so a non-power-of-two DEPTH still works.
    function automatic logic [c_PTR_W-1:0] ptrInc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign w_doPush = push && (r_count != CNT_W'(DEPTH)) && !clear;
    assign w_doPop  = pop  && (r_count != '0)            && !clear;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= ptrInc(r_wrPtr);
            if (w_doPop)  r_rdPtr <= ptrInc(r_rdPtr);
            r_count <= r_count + CNT_W'(w_doPush) - CNT_W'(w_doPop);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= pushData;
    end

    assign head  = r_mem[r_rdPtr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_queue
//  Description : Instruction prefetch queue in front of the IF/ID register.
//                Issues in-order word reads, buffers up to DEPTH returned
//                instructions with their PCs and hands them to decode over a
//                valid/ready handshake. A redirect flushes the queue, marks
//                every in-flight read as stale and restarts at the target.
//  Ports       : clk, rst            clock / synchronous active-high reset
//                mem_req, mem_addr   read request and word address
//                mem_gnt             memory accepts the request this cycle
//                mem_rvalid, mem_rdata  in-order read response
//                redirect, redirect_pc  taken branch/jump from Execute
//                inst_valid, inst, inst_pc  head of the queue
//                inst_ready          decode consumes the head (= !StallD)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int               c_CNT_W   = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W:0] c_DEPTH_X = (c_CNT_W + 1)'(DEPTH);

    logic [XLEN-1:0]    r_fetchPc;      // next address to request
    logic [XLEN-1:0]    r_respPc;       // PC tagged onto the next kept response
    logic [c_CNT_W-1:0] r_inflight;     // granted requests not yet answered
    logic [c_CNT_W-1:0] r_stale;        // oldest in-flight replies to drop

    logic [c_CNT_W-1:0] w_count;
    fetch_entry_t       w_head;
    fetch_entry_t       w_pushEntry;
    logic [c_CNT_W:0]   w_outstanding;
    logic               w_memReq;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_clear;
    logic [c_CNT_W-1:0] w_inflightNext;

    // Every slot is reserved at issue time, so a reply always has room.
    assign w_outstanding = {1'b0, w_count} + {1'b0, r_inflight};
    assign w_memReq      = !rst && !redirect && (w_outstanding < c_DEPTH_X);
    assign w_issue       = w_memReq && mem_gnt;

    assign w_push      = mem_rvalid && (r_stale == '0);
    assign w_pop       = inst_valid && inst_ready;
    assign w_clear     = rst || redirect;
    assign w_pushEntry = '{inst: mem_rdata, pc: r_respPc};

    // Includes this cycle's reply, so a reply landing in the redirect cycle
    // is already counted out and is not marked stale a second time.
    assign w_inflightNext = r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(mem_rvalid);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Memory shares this reset and drops its pending replies.
            r_fetchPc  <= RESET_PC;
            r_respPc   <= RESET_PC;
            r_inflight <= '0;
            r_stale    <= '0;
        end else if (redirect) begin
            r_fetchPc  <= redirect_pc;
            r_respPc   <= redirect_pc;
            r_inflight <= w_inflightNext;
            r_stale    <= w_inflightNext;
        end else begin
            r_inflight <= w_inflightNext;
            if (w_issue) begin
                r_fetchPc <= r_fetchPc + PC_STEP;
            end
            if (mem_rvalid && (r_stale != '0)) begin
                r_stale <= r_stale - c_CNT_W'(1);
            end
            if (w_push) begin
                r_respPc <= r_respPc + PC_STEP;
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t)),
        .CNT_W (c_CNT_W)
    ) u_instFifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .push     (w_push),
        .pushData (w_pushEntry),
        .pop      (w_pop),
        .head     (w_head),
        .count    (w_count)
    );

    assign mem_req    = w_memReq;
    assign mem_addr   = r_fetchPc;
    assign inst_valid = (w_count != '0);
    assign inst       = inst_valid ? w_head.inst : NOP_INST;
    assign inst_pc    = inst_valid ? w_head.pc   : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch_queue
//  Description : Directed bench for fetch_prefetch_queue with an in-order
//                instruction memory model of programmable latency and an
//                expected-PC scoreboard on every accepted instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memReq_t;

    memReq_t     memQ[$];
    int          cyc      = 0;
    int          lat      = 1;
    int          errCount = 0;
    int          chkCount = 0;
    int          reqCount = 0;
    int          popCount = 0;
    logic [31:0] expPc    = RESET_PC;

    // Values sampled 1 ns into the most recent step (before its clock edge).
    logic        lastReq;
    logic [31:0] lastAddr;
    logic        lastValid;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample at +1 ns,
    // update the memory model and scoreboard across the rising edge.
    task automatic step(input logic g, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input logic rs);
        logic        accepted;
        logic        responded;
        logic        popped;
        logic [31:0] reqAddr;
        mem_gnt     = g;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        rst         = rs;
        if (!rs && memQ.size() > 0 && memQ[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memData(memQ[0].addr);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hBAD0_BAD0;
        end
        #1;
        lastReq   = mem_req;
        lastAddr  = mem_addr;
        lastValid = inst_valid;
        accepted  = mem_req && mem_gnt;
        responded = mem_rvalid;
        reqAddr   = mem_addr;
        popped    = inst_valid && inst_ready && !rd && !rs;
        if (popped) begin
            checkEq("inst_pc", inst_pc, expPc);
            checkEq("inst", inst, memData(expPc));
            expPc = expPc + 32'd4;
            popCount++;
        end
        if (rs)      expPc = RESET_PC;
        else if (rd) expPc = rpc;
        if (accepted) reqCount++;
        @(posedge clk);
        cyc++;
        if (rs) begin
            memQ.delete();
        end else begin
            if (responded) void'(memQ.pop_front());
            if (accepted)  memQ.push_back('{addr: reqAddr, due: cyc + lat - 1});
        end
        checkEq("outstanding_le_depth", 32'(memQ.size() <= DEPTH), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops0;
        rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        @(negedge clk);

        // ---- reset state, then fill with 1-cycle memory ----
        lat = 1;
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        checkEq("rst_mem_req", 32'(lastReq), 32'd0);
        checkEq("rst_mem_addr", mem_addr, RESET_PC);
        checkEq("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkEq("rst_inst", inst, NOP_INST);
        checkEq("rst_inst_pc", inst_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("first_req", 32'(lastReq), 32'd1);
        checkEq("first_addr", lastAddr, RESET_PC);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("fill_not_yet_valid", 32'(lastValid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            checkEq("steady_valid", 32'(lastValid), 32'd1);
        end

        // ---- back-pressure: exactly DEPTH requests, then one per pop ----
        step(1'b1, 1'b0, 1'b1, 32'h200, 1'b0);
        checkEq("redir_blocks_req", 32'(lastReq), 32'd0);
        reqCount = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkEq("redir_next_req", 32'(lastReq), 32'd1);
        checkEq("redir_next_addr", lastAddr, 32'h200);
        repeat (9) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkEq("full_req_count", 32'(reqCount), 32'd4);
        checkEq("full_req_low", 32'(lastReq), 32'd0);
        checkEq("full_valid", 32'(lastValid), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("pop_no_comb_req", 32'(lastReq), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("resume_req", 32'(lastReq), 32'd1);
        checkEq("resume_addr", lastAddr, 32'h210);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // ---- redirect with 2 queued, 2 in flight, reply in same cycle ----
        lat = 3;
        repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h300, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
        checkEq("late_redir_valid_before", 32'(lastValid), 32'd1);
        checkEq("late_redir_no_req", 32'(lastReq), 32'd0);
        pops0 = popCount;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("late_redir_valid_drop", 32'(lastValid), 32'd0);
        checkEq("late_redir_req", 32'(lastReq), 32'd1);
        checkEq("late_redir_addr", lastAddr, 32'h100);
        repeat (14) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("late_redir_progress", 32'(popCount - pops0 >= 4), 32'd1);

        // ---- redirect colliding with a reply and a pop; address wrap ----
        lat = 1;
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        checkEq("collide_valid_before", 32'(lastValid), 32'd1);
        pops0 = popCount;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("collide_valid_drop", 32'(lastValid), 32'd0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("wrap_progress", 32'(popCount - pops0 >= 4), 32'd1);

        // ---- latency 3 with random grant and ready stalls ----
        lat = 3;
        pops0 = popCount;
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 1'b0, 32'h0, 1'b0);
        end
        checkEq("random_progress", 32'(popCount - pops0 > 20), 32'd1);

        // ---- reset mid-stream with entries queued ----
        lat = 1;
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        checkEq("midrst_queued", 32'(lastValid), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        checkEq("midrst_inst_valid", 32'(inst_valid), 32'd0);
        checkEq("midrst_inst", inst, NOP_INST);
        checkEq("midrst_inst_pc", inst_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("midrst_req", 32'(lastReq), 32'd1);
        checkEq("midrst_addr", lastAddr, RESET_PC);
        pops0 = popCount;
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        checkEq("midrst_progress", 32'(popCount - pops0 >= 4), 32'd1);

        $display("Result: errors=%0d of %0d checks", errCount, chkCount);
        $finish;
    end

endmodule
`default_nettype wire
